cplx_delay_line: RTL and testbench
==================================

Name: cplx_delay_line

Overview:
- Parametrised complex-sample delay line for the radix-5 FFT datapath. Generalises the fixed nine-stage real/imag register buffers.
- Delay depth is selectable at run time, from 1 to MAX_DEPTH advances.
- Supports stall via an advance enable and carries a valid flag alongside each sample.
- Sits between butterfly stages and twiddle multipliers to align pipeline branches of unequal latency.

Parameters:
- DATA_W, 32, width of each of the real and imaginary components (two's complement).
- MAX_DEPTH, 16, maximum supported delay in advances; must be at least 2.
- SEL_W, 5, width of delay_sel; must satisfy 2^SEL_W > MAX_DEPTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  advance enable; when 0 all state holds.
- in_valid  in  1  qualifies a_re/a_img on an advancing edge.
- a_re  in  DATA_W  real input sample.
- a_img  in  DATA_W  imaginary input sample.
- delay_sel  in  SEL_W  requested delay D in advances.
- a1_re  out  DATA_W  delayed real output, registered.
- a1_img  out  DATA_W  delayed imaginary output, registered.
- out_valid  out  1  qualifies a1_re/a1_img.
- cfg_err  out  1  sticky flag: delay_sel was out of range.

Behaviour:
- Clock and reset:
  - Single clock domain. Reset is synchronous and active-low: sampled only on the rising edge of clk while rst_n=0.
  - On reset: a1_re=0, a1_img=0, out_valid=0, cfg_err=0.
  - On reset: write pointer=0, fill counter=0, all stored valid bits=0, D_eff latched to the clamped value of delay_sel.
  - Stored data words are not reset.
  - Reset asserted mid-stream discards all in-flight samples. No stale valid sample may appear after reset.
- Advance:
  - An advance is a rising edge with rst_n=1 and en=1.
  - On an advance: {in_valid, a_re, a_img} is written at the write pointer, and the pointer increments modulo MAX_DEPTH.
  - Outputs load the entry written D_eff-1 advances before the current one.
  - D=1 therefore gives one-register delay. D=9 is cycle-equivalent to a nine-register chain when en is held at 1.
- Stall: with en=0, nothing changes, including the outputs and the fill counter. Latency is counted in advances, not cycles.
- Valid and fill:
  - out_valid = stored valid bit of the selected entry AND (fill counter >= D_eff).
  - The fill counter saturates at MAX_DEPTH and increments on each advance.
  - Data outputs update on every advance regardless of valid.
- Delay select:
  - delay_sel is sampled on every advance.
  - If the clamped value differs from D_eff: D_eff is updated and the fill counter is cleared to 0 on that edge, so out_valid is 0 on that edge.
  - out_valid stays 0 until D_eff further advances have occurred.
  - The write pointer is not disturbed by a delay change.
- Out-of-range select:
  - delay_sel=0 clamps to 1; delay_sel>MAX_DEPTH clamps to MAX_DEPTH.
  - Either case sets cfg_err. cfg_err clears only on reset.
- Wrap-around: the pointer wraps at MAX_DEPTH-1 to 0. Read address = (wp - (D_eff-1)) mod MAX_DEPTH, where wp is the address written this edge. No gap or repeat is permitted at the wrap.
- Simultaneous reset and en=1: reset wins; no write occurs.
- Storage: MAX_DEPTH x (2*DATA_W+1) register array. No combinational path from inputs to outputs.

Optional Feature:
- Macro: CPLX_DLY_CONJ_EN.
- When defined:
  - Adds input port conj (1 bit), sampled with the data on each advance and stored per entry.
  - When the stored conj bit of the output entry is 1, a1_img = -(stored imag), for the IFFT path.
  - Negation of -2^(DATA_W-1) saturates to 2^(DATA_W-1)-1.
  - a1_re is unaffected.
- When undefined: no conj port, no extra storage, imag passes unchanged.

Test Plan:
- Fixed delay: reset, then delay_sel=9, en=1, in_valid=1, a_re=k, a_img=100+k for k=1..20. First out_valid=1 sample appears on the 9th advance with a1_re=1, a1_img=101, then k increments each cycle.
- Stall: delay_sel=4, feed k=1..10 with en deasserted for 3 cycles after k=5. Outputs and out_valid freeze during the stall, and the sequence resumes with no lost or duplicated samples.
- Wrap and max depth: delay_sel=16, MAX_DEPTH=16, feed 40 samples. Output lags input by exactly 16 advances across both pointer wraps.
- Delay change: stream at D=3, switch delay_sel to 6 mid-stream. out_valid=0 on the switch edge and the next 5 advances, then returns with output = input from 6 advances earlier.
- Config error and reset: delay_sel=0 gives 1-advance delay and cfg_err=1; delay_sel=20 clamps to 16 with cfg_err=1. Pulsing rst_n=0 for one edge mid-stream yields out_valid=0, a1_re=a1_img=0, cfg_err=0, and no pre-reset samples afterwards.
- CPLX_DLY_CONJ_EN defined: D=2, feed a_img=5 with conj=1, then a_img=-2147483648 with conj=1, then a_img=7 with conj=0. Outputs a1_img = -5, then 2147483647, then 7.

Source files
------------

// File: rtl/cplx_delay_line.sv
// cplx_delay_line: complex-sample delay line with a run-time selectable depth
// (1..MAX_DEPTH advances), an advance enable for stalls, a valid flag carried
// with every sample, and a sticky flag for out-of-range delay requests.
// Optional feature macro: CPLX_DLY_CONJ_EN adds a per-sample conj input that
// negates the delayed imaginary part (saturating) for the IFFT path.
module cplx_delay_line #(
  parameter int DATA_W    = 32,
  parameter int MAX_DEPTH = 16,
  parameter int SEL_W     = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] a_re,
  input  logic [DATA_W-1:0] a_img,
  input  logic [SEL_W-1:0]  delay_sel,
`ifdef CPLX_DLY_CONJ_EN
  input  logic              conj,
`endif
  output logic [DATA_W-1:0] a1_re,
  output logic [DATA_W-1:0] a1_img,
  output logic              out_valid,
  output logic              cfg_err
);

  localparam int               PTR_W     = (MAX_DEPTH > 2) ? $clog2(MAX_DEPTH) : 1;
  localparam logic [SEL_W-1:0] MAX_SEL   = SEL_W'(MAX_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(MAX_DEPTH - 1);
  localparam logic [PTR_W:0]   DEPTH_EXT = (PTR_W + 1)'(MAX_DEPTH);

  // Sample storage; data words carry no reset, only the valid bits do.
  logic [DATA_W-1:0]    memRe_q [MAX_DEPTH];
  logic [DATA_W-1:0]    memIm_q [MAX_DEPTH];
  logic [MAX_DEPTH-1:0] memVld_q;
`ifdef CPLX_DLY_CONJ_EN
  logic [MAX_DEPTH-1:0] memConj_q;
`endif

  logic [PTR_W-1:0]  wrPtr_q,  wrPtr_d;
  logic [SEL_W-1:0]  fill_q,   fill_d;
  logic [SEL_W-1:0]  dEff_q,   dEff_d;
  logic              cfgErr_q, cfgErr_d;
  logic [DATA_W-1:0] a1Re_q,   a1Re_d;
  logic [DATA_W-1:0] a1Im_q,   a1Im_d;
  logic              outVld_q, outVld_d;

  logic              selBad;
  logic [SEL_W-1:0]  selClamp;
  logic [PTR_W:0]    rdRaw;
  logic [PTR_W:0]    rdWrap;
  logic [PTR_W-1:0]  rdPtr;
  logic              selVld;
  logic [DATA_W-1:0] selRe;
  logic [DATA_W-1:0] selIm;
  logic [DATA_W-1:0] imgOut;

  // Clamp the requested delay into 1..MAX_DEPTH and flag requests outside it.
  always_comb begin
    selBad   = (delay_sel == '0) || (delay_sel > MAX_SEL);
    selClamp = delay_sel;
    if (delay_sel == '0) begin
      selClamp = SEL_W'(1);
    end else if (delay_sel > MAX_SEL) begin
      selClamp = MAX_SEL;
    end
  end

  // Read address is D-1 entries behind the slot written this edge; when it
  // equals the write slot (D=1) the incoming sample is forwarded directly.
  always_comb begin
    rdRaw  = {1'b0, wrPtr_q} + DEPTH_EXT - {1'b0, PTR_W'(selClamp - 1'b1)};
    rdWrap = (rdRaw >= DEPTH_EXT) ? (rdRaw - DEPTH_EXT) : rdRaw;
    rdPtr  = rdWrap[PTR_W-1:0];
    if (rdPtr == wrPtr_q) begin
      selVld = in_valid;
      selRe  = a_re;
      selIm  = a_img;
    end else begin
      selVld = memVld_q[rdPtr];
      selRe  = memRe_q[rdPtr];
      selIm  = memIm_q[rdPtr];
    end
  end

`ifdef CPLX_DLY_CONJ_EN
  logic selConj;

  // Conjugate the selected sample when its stored conj bit is set; the most
  // negative value has no positive twin, so it saturates to the largest one.
  always_comb begin
    selConj = (rdPtr == wrPtr_q) ? conj : memConj_q[rdPtr];
    imgOut  = selIm;
    if (selConj) begin
      if (selIm == {1'b1, {(DATA_W-1){1'b0}}}) begin
        imgOut = {1'b0, {(DATA_W-1){1'b1}}};
      end else begin
        imgOut = '0 - selIm;
      end
    end
  end
`else
  // Without the conjugate option the imaginary part passes through untouched.
  always_comb begin
    imgOut = selIm;
  end
`endif

  // Next-state for pointer, fill counter, delay, error flag and outputs on an advance.
  always_comb begin
    wrPtr_d  = wrPtr_q;
    fill_d   = fill_q;
    dEff_d   = dEff_q;
    cfgErr_d = cfgErr_q;
    a1Re_d   = a1Re_q;
    a1Im_d   = a1Im_q;
    outVld_d = outVld_q;
    if (en) begin
      wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + 1'b1;
      if (selClamp != dEff_q) begin
        dEff_d = selClamp;
        fill_d = '0;
      end else if (fill_q < MAX_SEL) begin
        fill_d = fill_q + 1'b1;
      end
      if (selBad) begin
        cfgErr_d = 1'b1;
      end
      a1Re_d   = selRe;
      a1Im_d   = imgOut;
      outVld_d = selVld && (fill_d >= dEff_d);
    end
  end

  // Control state, valid bits and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wrPtr_q  <= '0;
      fill_q   <= '0;
      dEff_q   <= selClamp;
      cfgErr_q <= 1'b0;
      a1Re_q   <= '0;
      a1Im_q   <= '0;
      outVld_q <= 1'b0;
      memVld_q <= '0;
    end else begin
      wrPtr_q  <= wrPtr_d;
      fill_q   <= fill_d;
      dEff_q   <= dEff_d;
      cfgErr_q <= cfgErr_d;
      a1Re_q   <= a1Re_d;
      a1Im_q   <= a1Im_d;
      outVld_q <= outVld_d;
      if (en) begin
        memVld_q[wrPtr_q] <= in_valid;
      end
    end
  end

  // Data words are written on every advance and are never cleared.
  always_ff @(posedge clk) begin
    if (rst_n && en) begin
      memRe_q[wrPtr_q] <= a_re;
      memIm_q[wrPtr_q] <= a_img;
`ifdef CPLX_DLY_CONJ_EN
      memConj_q[wrPtr_q] <= conj;
`endif
    end
  end

  assign a1_re     = a1Re_q;
  assign a1_img    = a1Im_q;
  assign out_valid = outVld_q;
  assign cfg_err   = cfgErr_q;

endmodule

// File: tb/tb_cplx_delay_line.sv
// tb_cplx_delay_line: directed-vector bench for cplx_delay_line covering fixed
// delay, stall, wrap at maximum depth, delay change, clamping and reset, plus
// the conjugate path when CPLX_DLY_CONJ_EN is defined.
module tb_cplx_delay_line;

  localparam int DATA_W    = 32;
  localparam int MAX_DEPTH = 16;
  localparam int SEL_W     = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              en = 1'b0;
  logic              in_valid = 1'b0;
  logic [DATA_W-1:0] a_re = '0;
  logic [DATA_W-1:0] a_img = '0;
  logic [SEL_W-1:0]  delay_sel = '0;
  logic              conj = 1'b0;
  logic [DATA_W-1:0] a1_re;
  logic [DATA_W-1:0] a1_img;
  logic              out_valid;
  logic              cfg_err;

  int vectors = 0;
  int miscompares = 0;

  // Free-running 10-unit clock.
  always #5 clk = ~clk;

  cplx_delay_line #(
    .DATA_W   (DATA_W),
    .MAX_DEPTH(MAX_DEPTH),
    .SEL_W    (SEL_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .in_valid (in_valid),
    .a_re     (a_re),
    .a_img    (a_img),
    .delay_sel(delay_sel),
`ifdef CPLX_DLY_CONJ_EN
    .conj     (conj),
`endif
    .a1_re    (a1_re),
    .a1_img   (a1_img),
    .out_valid(out_valid),
    .cfg_err  (cfg_err)
  );

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic enI, input logic vldI, input int re, input int im,
                               input int sel);
    en        = enI;
    in_valid  = vldI;
    a_re      = DATA_W'(re);
    a_img     = DATA_W'(im);
    delay_sel = sel[SEL_W-1:0];
    @(posedge clk);
    #1;
  endtask

  task automatic doReset(input int sel);
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b1, 555, 555, sel);
    rst_n = 1'b1;
  endtask

  initial begin
    $display("[TB] start");

    // Reset state
    doReset(9);
    checkOutput("rst_re", 64'(a1_re), 64'd0);
    checkOutput("rst_im", 64'(a1_img), 64'd0);
    checkOutput("rst_vld", 64'(out_valid), 64'd0);
    checkOutput("rst_err", 64'(cfg_err), 64'd0);

    // Fixed delay of 9: first valid sample on the 9th advance
    for (int k = 1; k <= 20; k++) begin
      applyStimulus(1'b1, 1'b1, k, 100 + k, 9);
      checkOutput("d9_vld", 64'(out_valid), (k >= 9) ? 64'd1 : 64'd0);
      if (k >= 9) begin
        checkOutput("d9_re", 64'(a1_re), 64'(k - 8));
        checkOutput("d9_im", 64'(a1_img), 64'(100 + k - 8));
      end
    end

    // Stall at delay 4: outputs freeze, no samples lost or repeated
    doReset(4);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b1, k, 100 + k, 4);
      checkOutput("st_vld", 64'(out_valid), (k >= 4) ? 64'd1 : 64'd0);
      if (k >= 4) begin
        checkOutput("st_re", 64'(a1_re), 64'(k - 3));
        checkOutput("st_im", 64'(a1_img), 64'(100 + k - 3));
      end
      if (k == 5) begin
        for (int s = 0; s < 3; s++) begin
          applyStimulus(1'b0, 1'b1, 999, 999, 7);
          checkOutput("stall_re", 64'(a1_re), 64'd2);
          checkOutput("stall_vld", 64'(out_valid), 64'd1);
        end
      end
    end

    // Maximum depth across two pointer wraps
    doReset(16);
    for (int k = 1; k <= 40; k++) begin
      applyStimulus(1'b1, 1'b1, k, 1000 + k, 16);
      checkOutput("d16_vld", 64'(out_valid), (k >= 16) ? 64'd1 : 64'd0);
      if (k >= 16) begin
        checkOutput("d16_re", 64'(a1_re), 64'(k - 15));
      end
    end

    // Delay change from 3 to 6 mid-stream
    doReset(3);
    for (int k = 1; k <= 10; k++) begin
      applyStimulus(1'b1, 1'b1, k, 200 + k, 3);
      if (k >= 3) begin
        checkOutput("d3_re", 64'(a1_re), 64'(k - 2));
      end
    end
    for (int k = 11; k <= 25; k++) begin
      applyStimulus(1'b1, 1'b1, k, 200 + k, 6);
      checkOutput("chg_vld", 64'(out_valid), (k >= 17) ? 64'd1 : 64'd0);
      if (k >= 17) begin
        checkOutput("chg_re", 64'(a1_re), 64'(k - 5));
        checkOutput("chg_im", 64'(a1_img), 64'(200 + k - 5));
      end
    end

    // Out-of-range selects: 0 clamps to 1, 20 clamps to 16
    doReset(0);
    checkOutput("clr_err", 64'(cfg_err), 64'd0);
    for (int k = 1; k <= 4; k++) begin
      applyStimulus(1'b1, 1'b1, k, 300 + k, 0);
      checkOutput("d0_vld", 64'(out_valid), 64'd1);
      checkOutput("d0_re", 64'(a1_re), 64'(k));
      checkOutput("d0_err", 64'(cfg_err), 64'd1);
    end
    for (int k = 5; k <= 25; k++) begin
      applyStimulus(1'b1, 1'b1, k, 300 + k, 20);
      checkOutput("d20_vld", 64'(out_valid), (k >= 21) ? 64'd1 : 64'd0);
      if (k >= 21) begin
        checkOutput("d20_re", 64'(a1_re), 64'(k - 15));
      end
    end
    checkOutput("d20_err", 64'(cfg_err), 64'd1);

    // One-edge reset pulse mid-stream discards everything in flight
    doReset(16);
    checkOutput("pulse_re", 64'(a1_re), 64'd0);
    checkOutput("pulse_im", 64'(a1_img), 64'd0);
    checkOutput("pulse_vld", 64'(out_valid), 64'd0);
    checkOutput("pulse_err", 64'(cfg_err), 64'd0);
    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b1, 1'b1, 100 + k, 400 + k, 16);
      checkOutput("post_vld", 64'(out_valid), (k == 15) ? 64'd1 : 64'd0);
    end
    checkOutput("post_re", 64'(a1_re), 64'd100);
    checkOutput("post_im", 64'(a1_img), 64'd400);

`ifdef CPLX_DLY_CONJ_EN
    // Conjugate path at delay 2, including saturation of the most negative value
    doReset(2);
    conj = 1'b1;
    applyStimulus(1'b1, 1'b1, 1, 5, 2);
    conj = 1'b1;
    applyStimulus(1'b1, 1'b1, 2, 32'h8000_0000, 2);
    checkOutput("cj_neg5", 64'(a1_img), 64'hFFFF_FFFB);
    conj = 1'b0;
    applyStimulus(1'b1, 1'b1, 3, 7, 2);
    checkOutput("cj_sat", 64'(a1_img), 64'h7FFF_FFFF);
    applyStimulus(1'b1, 1'b1, 4, 9, 2);
    checkOutput("cj_pass", 64'(a1_img), 64'd7);
    checkOutput("cj_re", 64'(a1_re), 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
